// File: rtl/filter_seq_ctrl.sv
// rtl/filter_seq_ctrl.sv - sequencer for the 7-tap byte FIR datapath: parameter load, sample issue, result capture
module filter_seq_ctrl #(
    parameter int          Y_LAT    = 8,
    parameter int          N_CFG    = 8,
    parameter logic [15:0] CFG_BASE = 16'h0000
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [7:0]  cfg_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic        configured,
    output logic        busy,
    output logic        flt_w_en_n,
    output logic [7:0]  flt_p,
    output logic [15:0] flt_addr,
    output logic        flt_x_valid_n,
    output logic [7:0]  flt_x,
    input  logic [7:0]  flt_y
);

    localparam int CNT_W = $clog2(Y_LAT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CFG   = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        CAP   = 3'd4
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [3:0]         cfg_idx;
    logic [CNT_W-1:0]   wait_cnt;
    logic               cfg_hs;
    logic               s_hs;
    logic               m_hs;
    logic               last_byte;

    assign last_byte = (cfg_idx == 4'(N_CFG - 1));

    // State register
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; WAIT leaves on the edge that takes the counter to zero so CAP
    // lines up with the first cycle flt_y holds the new result
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cfg_hs) begin
                    next_state = last_byte ? IDLE : CFG;
                end else if (s_hs) begin
                    next_state = ISSUE;
                end
            end
            CFG: begin
                if (cfg_hs && last_byte) begin
                    next_state = IDLE;
                end
            end
            ISSUE:   next_state = WAIT;
            WAIT: begin
                if (wait_cnt <= CNT_W'(1)) begin
                    next_state = CAP;
                end
            end
            CAP:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs; config beats samples in IDLE, no sample while a result is pending
    always_comb begin
        cfg_ready = (state == IDLE) || (state == CFG);
        s_ready   = (state == IDLE) && configured && !m_valid && !cfg_valid;
        busy      = (state != IDLE);
        cfg_hs    = cfg_valid && cfg_ready;
        s_hs      = s_valid && s_ready;
        m_hs      = m_valid && m_ready;
    end

    // Registered datapath strobes, parameter index, wait counter and result holding register
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            cfg_idx       <= 4'd0;
            configured    <= 1'b0;
            m_valid       <= 1'b0;
            m_data        <= 8'h00;
            flt_w_en_n    <= 1'b1;
            flt_p         <= 8'h00;
            flt_addr      <= CFG_BASE;
            flt_x_valid_n <= 1'b1;
            flt_x         <= 8'h00;
            wait_cnt      <= '0;
        end else begin
            flt_w_en_n    <= !cfg_hs;
            flt_x_valid_n <= !s_hs;

            if (cfg_hs) begin
                flt_p    <= cfg_data;
                flt_addr <= CFG_BASE | {12'h000, cfg_idx};
                if (last_byte) begin
                    cfg_idx    <= 4'd0;
                    configured <= 1'b1;
                end else begin
                    cfg_idx <= cfg_idx + 4'd1;
                    if (cfg_idx == 4'd0) begin
                        configured <= 1'b0;
                    end
                end
            end

            if (s_hs) begin
                flt_x <= s_data;
            end

            if (state == ISSUE) begin
                wait_cnt <= CNT_W'(Y_LAT);
            end else if (state == WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - CNT_W'(1);
            end

            if (state == CAP) begin
                m_data  <= flt_y;
                m_valid <= 1'b1;
            end else if (m_hs) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_filter_seq_ctrl.sv
// tb/tb_filter_seq_ctrl.sv - directed scoreboard bench for filter_seq_ctrl with a behavioural FIR datapath
module tb_filter_seq_ctrl;

    localparam int Y_LAT = 8;

    logic        clock = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [7:0]  cfg_data;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        configured;
    logic        busy;
    logic        flt_w_en_n;
    logic [7:0]  flt_p;
    logic [15:0] flt_addr;
    logic        flt_x_valid_n;
    logic [7:0]  flt_x;
    logic [7:0]  flt_y;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int issues = 0;
    int issue_edge = 0;
    int hs_edge = 0;
    int pop_edge = 0;
    logic mv_q = 1'b0;
    logic [7:0] exp_q[$];

    logic [7:0] prm  [8];
    logic [7:0] hist [6];
    logic [7:0] pend;
    int         dcnt;

    filter_seq_ctrl #(.Y_LAT(Y_LAT), .N_CFG(8), .CFG_BASE(16'h0000)) dut (
        .clock         (clock),
        .rst           (rst),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_data      (cfg_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .configured    (configured),
        .busy          (busy),
        .flt_w_en_n    (flt_w_en_n),
        .flt_p         (flt_p),
        .flt_addr      (flt_addr),
        .flt_x_valid_n (flt_x_valid_n),
        .flt_x         (flt_x),
        .flt_y         (flt_y)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] fir(input logic [7:0] xm);
        logic [7:0] acc;
        acc = 8'(prm[0] * xm);
        for (int k = 1; k < 7; k++) begin
            acc = 8'(acc + 8'(prm[k] * hist[k-1]));
        end
        return acc;
    endfunction

    // Behavioural datapath: parameter file, masked sample history, result valid Y_LAT edges after sampling
    always @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) prm[i] <= 8'h00;
            for (int i = 0; i < 6; i++) hist[i] <= 8'h00;
            pend  <= 8'h00;
            dcnt  <= 0;
            flt_y <= 8'h00;
        end else begin
            if (!flt_w_en_n) prm[flt_addr[2:0]] <= flt_p;
            if (!flt_x_valid_n) begin
                pend    <= fir(flt_x & prm[7]);
                hist[0] <= flt_x & prm[7];
                for (int i = 1; i < 6; i++) hist[i] <= hist[i-1];
                dcnt  <= Y_LAT;
                flt_y <= 8'hEE;
            end else if (dcnt > 0) begin
                dcnt <= dcnt - 1;
                if (dcnt == 1) flt_y <= pend;
            end
        end
    end

    // Output monitor: issue counting, latency, scoreboard pop on result handshake
    always @(negedge clock) begin
        logic [7:0] e;
        if (!rst) begin
            if (!flt_x_valid_n) begin
                issues++;
                issue_edge = cyc;
            end
            if (s_valid && s_ready) hs_edge = cyc + 1;
            if (m_valid && !mv_q) check("latency", 16'(cyc - hs_edge), 16'(Y_LAT + 2));
            if (m_valid && m_ready) begin
                pop_edge = cyc + 1;
                check("sb_has_entry", 16'(exp_q.size() != 0), 16'h1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("m_data", 16'(m_data), 16'(e));
                end
            end
        end
        mv_q = m_valid;
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_m_valid"},    16'(m_valid), 16'h0);
        check({tag, "_m_data"},     16'(m_data), 16'h0);
        check({tag, "_configured"}, 16'(configured), 16'h0);
        check({tag, "_busy"},       16'(busy), 16'h0);
        check({tag, "_w_en_n"},     16'(flt_w_en_n), 16'h1);
        check({tag, "_x_valid_n"},  16'(flt_x_valid_n), 16'h1);
        check({tag, "_flt_p"},      16'(flt_p), 16'h0);
        check({tag, "_flt_addr"},   flt_addr, 16'h0000);
        check({tag, "_flt_x"},      16'(flt_x), 16'h0);
    endtask

    task automatic load_burst(input logic [7:0] b [8]);
        for (int i = 0; i < 8; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = b[i];
            step();
            check("wr_en", 16'(flt_w_en_n), 16'h0);
            check("wr_addr", flt_addr, 16'(i));
            check("wr_data", 16'(flt_p), 16'(b[i]));
            check("cfg_flag", 16'(configured), 16'(i == 7));
        end
        cfg_valid = 1'b0;
        step();
        check("wr_idle", 16'(flt_w_en_n), 16'h1);
        check("configured", 16'(configured), 16'h1);
        check("cfg_busy", 16'(busy), 16'h0);
    endtask

    task automatic send(input logic [7:0] v, input logic [7:0] e);
        int n = 0;
        s_data  = v;
        s_valid = 1'b1;
        #1;
        while (!s_ready && n < 50) begin
            step();
            n++;
        end
        check("s_accept", 16'(s_ready), 16'h1);
        exp_q.push_back(e);
        step();
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < 100) begin
            step();
            n++;
        end
        check("drain_in_time", 16'(n < 100), 16'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] burst1 [8];
        logic [7:0] burst2 [8];
        int iss0;
        int n;

        burst1 = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'hFF};
        burst2 = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F};

        rst = 1'b1; cfg_valid = 1'b0; cfg_data = 8'h00;
        s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b1;
        repeat (3) step();
        check_reset("rst0");
        rst = 1'b0;

        // 1: sample without configuration is never admitted
        iss0 = issues;
        s_valid = 1'b1; s_data = 8'h55;
        repeat (6) step();
        check("noconf_s_ready", 16'(s_ready), 16'h0);
        check("noconf_issues", 16'(issues - iss0), 16'h0);
        check("noconf_configured", 16'(configured), 16'h0);
        s_valid = 1'b0;

        // 2: unity coefficients, full mask
        load_burst(burst1);

        // 3: running sums
        m_ready = 1'b1;
        send(8'h01, 8'h01); drain();
        send(8'h02, 8'h03); drain();
        send(8'h03, 8'h06); drain();

        // 4: config wins over a simultaneous sample, then reload and one sample
        cfg_valid = 1'b1; s_valid = 1'b1; s_data = 8'h35;
        #1;
        check("cfg_priority_s_ready", 16'(s_ready), 16'h0);
        s_valid = 1'b0; cfg_valid = 1'b0;
        #1;
        load_burst(burst2);
        send(8'h35, 8'h0A); drain();

        // 5: back-pressure holds the result and blocks further issues
        m_ready = 1'b0;
        iss0 = issues;
        s_data = 8'h07; s_valid = 1'b1;
        #1;
        n = 0;
        while (!s_ready && n < 50) begin step(); n++; end
        check("t5_accept", 16'(s_ready), 16'h1);
        exp_q.push_back(8'h0E);
        step();
        s_data = 8'h08;
        repeat (12) step();
        check("t5_mid_valid", 16'(m_valid), 16'h1);
        check("t5_mid_data", 16'(m_data), 16'h0E);
        repeat (8) step();
        check("t5_one_issue", 16'(issues - iss0), 16'h1);
        check("t5_end_data", 16'(m_data), 16'h0E);
        check("t5_s_blocked", 16'(s_ready), 16'h0);
        exp_q.push_back(8'h10);
        m_ready = 1'b1;
        n = 0;
        while (issues < iss0 + 2 && n < 50) begin step(); n++; end
        check("t5_gap", 16'(issue_edge - pop_edge), 16'h1);
        s_valid = 1'b0;
        drain();

        // 6: reset in the middle of a computation
        send(8'h03, 8'h06);
        repeat (4) step();
        check("t6_busy", 16'(busy), 16'h1);
        rst = 1'b1;
        #1;
        check_reset("rst1");
        exp_q.delete();
        repeat (2) step();
        rst = 1'b0;
        iss0 = issues;
        s_valid = 1'b1; s_data = 8'h03;
        repeat (10) step();
        check("t6_s_ready", 16'(s_ready), 16'h0);
        check("t6_no_issue", 16'(issues - iss0), 16'h0);
        check("t6_configured", 16'(configured), 16'h0);
        s_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
